// File: rtl/readout_cds_diff_if.sv
// Bundle between the column sample buses and the CDS difference stage:
// lane-select and two packed sample buses in, registered difference out.
interface readout_cds_diff_if #(
   parameter int mux_width = 2,
   parameter int bus_width = 8
);
   localparam int sel_width = $clog2(mux_width);

   logic [sel_width-1:0]           select;
   logic [mux_width*bus_width-1:0] in1;
   logic [mux_width*bus_width-1:0] in2;
   logic                           in_valid;
   logic [bus_width-1:0]           sub_out;
   logic                           borrow;
   logic                           out_valid;

   modport master (
      output select, in1, in2, in_valid,
      input  sub_out, borrow, out_valid
   );

   modport slave (
      input  select, in1, in2, in_valid,
      output sub_out, borrow, out_valid
   );
endinterface

// File: rtl/readout_cds_diff.sv
// CDS difference stage: picks one lane from each sample bus, forms A - B and
// registers the result together with a borrow flag and a valid pulse.
module readout_cds_diff #(
   parameter int mux_width = 2,
   parameter int bus_width = 8,
   parameter bit saturate  = 1'b0
) (
   input logic              clk,
   input logic              reset,
   readout_cds_diff_if.slave bus
);
   localparam int sel_width = $clog2(mux_width);

   logic [bus_width-1:0] a;
   logic [bus_width-1:0] b;
   logic [bus_width:0]   diff_full;
   logic                 borrow_next;
   logic [bus_width-1:0] diff_next;

   // Select values past the last lane match nothing and leave both operands at 0.
   always_comb begin
      a = '0;
      b = '0;
      for (int k = 0; k < mux_width; k++) begin
         if (bus.select == sel_width'(k)) begin
            a = bus.in1[k*bus_width +: bus_width];
            b = bus.in2[k*bus_width +: bus_width];
         end
      end
   end

   always_comb begin
      diff_full   = {1'b0, a} - {1'b0, b};
      borrow_next = diff_full[bus_width];
      if (saturate && borrow_next)
         diff_next = '0;
      else
         diff_next = diff_full[bus_width-1:0];
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         bus.sub_out   <= '0;
         bus.borrow    <= 1'b0;
         bus.out_valid <= 1'b0;
      end else if (bus.in_valid) begin
         bus.sub_out   <= diff_next;
         bus.borrow    <= borrow_next;
         bus.out_valid <= 1'b1;
      end else begin
         bus.out_valid <= 1'b0;
      end
   end
endmodule

// File: tb/tb_readout_cds_diff.sv
// Bench for the CDS difference stage: wrap, saturating and three-lane variants
// checked against fixed scenarios and an integer-arithmetic reference model.
module tb_readout_cds_diff;
   logic clk = 1'b0;
   logic reset;
   int   vectors = 0;
   int   miscompares = 0;

   always #5 clk = ~clk;

   readout_cds_diff_if #(.mux_width(2), .bus_width(8)) if_mod ();
   readout_cds_diff_if #(.mux_width(2), .bus_width(8)) if_sat ();
   readout_cds_diff_if #(.mux_width(3), .bus_width(8)) if_odd ();

   readout_cds_diff #(.mux_width(2), .bus_width(8), .saturate(1'b0)) u_mod (
      .clk(clk), .reset(reset), .bus(if_mod));
   readout_cds_diff #(.mux_width(2), .bus_width(8), .saturate(1'b1)) u_sat (
      .clk(clk), .reset(reset), .bus(if_sat));
   readout_cds_diff #(.mux_width(3), .bus_width(8), .saturate(1'b0)) u_odd (
      .clk(clk), .reset(reset), .bus(if_odd));

   localparam logic [15:0] bus_a = {8'd200, 8'd85};
   localparam logic [15:0] bus_b = {8'd255, 8'd157};

   // returns {borrow, difference} from plain signed arithmetic
   function automatic logic [8:0] ref_model(input int a, input int b, input bit sat);
      int  d;
      logic bor;
      d   = a - b;
      bor = (d < 0);
      if (d < 0) d = sat ? 0 : d + 256;
      return {bor, 8'(d)};
   endfunction

   task automatic cycle(input logic [15:0] i1, input logic [15:0] i2,
                        input logic s, input logic v);
      if_mod.in1 = i1; if_mod.in2 = i2; if_mod.select = s; if_mod.in_valid = v;
      if_sat.in1 = i1; if_sat.in2 = i2; if_sat.select = s; if_sat.in_valid = v;
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      reset = 1'b1;
      cycle(bus_a, bus_b, 1'b0, 1'b1);
      cycle(bus_a, bus_b, 1'b0, 1'b1);
      vectors++;
      if ({if_mod.sub_out, if_mod.borrow, if_mod.out_valid} !== 10'd0) begin
         miscompares++;
         $display("FAIL reset_mod: got sub=%0d bor=%0b val=%0b want 0/0/0",
                  if_mod.sub_out, if_mod.borrow, if_mod.out_valid);
      end
      vectors++;
      if ({if_odd.sub_out, if_odd.borrow, if_odd.out_valid} !== 10'd0) begin
         miscompares++;
         $display("FAIL reset_odd: got sub=%0d bor=%0b val=%0b want 0/0/0",
                  if_odd.sub_out, if_odd.borrow, if_odd.out_valid);
      end
      reset = 1'b0;
   endtask

   task automatic test_first_lane();
      cycle(bus_a, bus_b, 1'b0, 1'b1);
      vectors++;
      if ({if_mod.sub_out, if_mod.borrow, if_mod.out_valid} !== {8'd184, 1'b1, 1'b1}) begin
         miscompares++;
         $display("FAIL first_lane: got sub=%0d bor=%0b val=%0b want 184/1/1",
                  if_mod.sub_out, if_mod.borrow, if_mod.out_valid);
      end
   endtask

   task automatic test_lane_switch();
      cycle(bus_a, bus_b, 1'b1, 1'b1);
      vectors++;
      if ({if_mod.sub_out, if_mod.borrow, if_mod.out_valid} !== {8'd201, 1'b1, 1'b1}) begin
         miscompares++;
         $display("FAIL lane_switch: got sub=%0d bor=%0b val=%0b want 201/1/1",
                  if_mod.sub_out, if_mod.borrow, if_mod.out_valid);
      end
      cycle(16'h1234, 16'h0077, 1'b0, 1'b0);
      vectors++;
      if ({if_mod.sub_out, if_mod.borrow, if_mod.out_valid} !== {8'd201, 1'b1, 1'b0}) begin
         miscompares++;
         $display("FAIL hold_idle: got sub=%0d bor=%0b val=%0b want 201/1/0",
                  if_mod.sub_out, if_mod.borrow, if_mod.out_valid);
      end
   endtask

   task automatic test_nonneg_equal();
      cycle({8'd0, 8'd157}, {8'd0, 8'd85}, 1'b0, 1'b1);
      vectors++;
      if ({if_mod.sub_out, if_mod.borrow, if_mod.out_valid} !== {8'd72, 1'b0, 1'b1}) begin
         miscompares++;
         $display("FAIL nonneg: got sub=%0d bor=%0b val=%0b want 72/0/1",
                  if_mod.sub_out, if_mod.borrow, if_mod.out_valid);
      end
      cycle({8'd9, 8'd42}, {8'd3, 8'd42}, 1'b0, 1'b1);
      vectors++;
      if ({if_mod.sub_out, if_mod.borrow, if_mod.out_valid} !== {8'd0, 1'b0, 1'b1}) begin
         miscompares++;
         $display("FAIL equal: got sub=%0d bor=%0b val=%0b want 0/0/1",
                  if_mod.sub_out, if_mod.borrow, if_mod.out_valid);
      end
   endtask

   task automatic test_saturation();
      cycle({8'd0, 8'd85}, {8'd0, 8'd157}, 1'b0, 1'b1);
      vectors++;
      if ({if_sat.sub_out, if_sat.borrow, if_sat.out_valid} !== {8'd0, 1'b1, 1'b1}) begin
         miscompares++;
         $display("FAIL sat_clamp: got sub=%0d bor=%0b val=%0b want 0/1/1",
                  if_sat.sub_out, if_sat.borrow, if_sat.out_valid);
      end
      vectors++;
      if ({if_mod.sub_out, if_mod.borrow} !== {8'd184, 1'b1}) begin
         miscompares++;
         $display("FAIL wrap_same_input: got sub=%0d bor=%0b want 184/1",
                  if_mod.sub_out, if_mod.borrow);
      end
      cycle({8'd0, 8'd255}, {8'd0, 8'd0}, 1'b0, 1'b1);
      vectors++;
      if ({if_sat.sub_out, if_sat.borrow, if_sat.out_valid} !== {8'd255, 1'b0, 1'b1}) begin
         miscompares++;
         $display("FAIL sat_max: got sub=%0d bor=%0b val=%0b want 255/0/1",
                  if_sat.sub_out, if_sat.borrow, if_sat.out_valid);
      end
   endtask

   task automatic test_streaming();
      int exp_seq[4] = '{184, 201, 184, 201};
      for (int i = 0; i < 4; i++) begin
         cycle(bus_a, bus_b, 1'(i % 2), 1'b1);
         vectors++;
         if ({if_mod.sub_out, if_mod.borrow, if_mod.out_valid} !== {8'(exp_seq[i]), 1'b1, 1'b1}) begin
            miscompares++;
            $display("FAIL stream[%0d]: got sub=%0d bor=%0b val=%0b want %0d/1/1",
                     i, if_mod.sub_out, if_mod.borrow, if_mod.out_valid, exp_seq[i]);
         end
      end
   endtask

   task automatic test_reset_midstream();
      reset = 1'b1;
      cycle(bus_a, bus_b, 1'b0, 1'b1);
      vectors++;
      if ({if_mod.sub_out, if_mod.borrow, if_mod.out_valid} !== 10'd0) begin
         miscompares++;
         $display("FAIL reset_mid: got sub=%0d bor=%0b val=%0b want 0/0/0",
                  if_mod.sub_out, if_mod.borrow, if_mod.out_valid);
      end
      reset = 1'b0;
      cycle(bus_a, bus_b, 1'b1, 1'b1);
      vectors++;
      if ({if_mod.sub_out, if_mod.borrow, if_mod.out_valid} !== {8'd201, 1'b1, 1'b1}) begin
         miscompares++;
         $display("FAIL resume: got sub=%0d bor=%0b val=%0b want 201/1/1",
                  if_mod.sub_out, if_mod.borrow, if_mod.out_valid);
      end
   endtask

   task automatic test_out_of_range();
      if_odd.in1 = {8'd77, 8'd66, 8'd55};
      if_odd.in2 = {8'd11, 8'd99, 8'd22};
      if_odd.select = 2'd3;
      if_odd.in_valid = 1'b1;
      @(posedge clk); #1;
      vectors++;
      if ({if_odd.sub_out, if_odd.borrow, if_odd.out_valid} !== {8'd0, 1'b0, 1'b1}) begin
         miscompares++;
         $display("FAIL select_oor: got sub=%0d bor=%0b val=%0b want 0/0/1",
                  if_odd.sub_out, if_odd.borrow, if_odd.out_valid);
      end
      if_odd.select = 2'd2;
      @(posedge clk); #1;
      vectors++;
      if ({if_odd.sub_out, if_odd.borrow, if_odd.out_valid} !== {8'd66, 1'b0, 1'b1}) begin
         miscompares++;
         $display("FAIL lane2: got sub=%0d bor=%0b val=%0b want 66/0/1",
                  if_odd.sub_out, if_odd.borrow, if_odd.out_valid);
      end
      if_odd.in_valid = 1'b0;
   endtask

   task automatic test_random();
      int         l1[2];
      int         l2[2];
      int         sel;
      bit         v;
      logic [8:0] em = '0;
      logic [8:0] es = '0;
      for (int n = 0; n < 60; n++) begin
         for (int k = 0; k < 2; k++) begin
            l1[k] = $urandom_range(255);
            l2[k] = $urandom_range(255);
         end
         if (n % 7 == 0) l2[0] = l1[0];
         sel = $urandom_range(1);
         v   = (n == 0) ? 1'b1 : 1'($urandom_range(3) != 0);
         if (v) begin
            em = ref_model(l1[sel], l2[sel], 1'b0);
            es = ref_model(l1[sel], l2[sel], 1'b1);
         end
         cycle({8'(l1[1]), 8'(l1[0])}, {8'(l2[1]), 8'(l2[0])}, 1'(sel), 1'(v));
         vectors++;
         if ({if_mod.borrow, if_mod.sub_out, if_mod.out_valid} !== {em, v}) begin
            miscompares++;
            $display("FAIL rand_mod[%0d]: got sub=%0d bor=%0b val=%0b want %0d/%0b/%0b",
                     n, if_mod.sub_out, if_mod.borrow, if_mod.out_valid, em[7:0], em[8], v);
         end
         vectors++;
         if ({if_sat.borrow, if_sat.sub_out, if_sat.out_valid} !== {es, v}) begin
            miscompares++;
            $display("FAIL rand_sat[%0d]: got sub=%0d bor=%0b val=%0b want %0d/%0b/%0b",
                     n, if_sat.sub_out, if_sat.borrow, if_sat.out_valid, es[7:0], es[8], v);
         end
      end
   endtask

   task automatic test_random_odd();
      int         l1[3];
      int         l2[3];
      int         sel;
      logic [8:0] eo;
      logic [23:0] p1;
      logic [23:0] p2;
      for (int n = 0; n < 20; n++) begin
         for (int k = 0; k < 3; k++) begin
            l1[k] = $urandom_range(255);
            l2[k] = $urandom_range(255);
         end
         sel = $urandom_range(3);
         p1  = {8'(l1[2]), 8'(l1[1]), 8'(l1[0])};
         p2  = {8'(l2[2]), 8'(l2[1]), 8'(l2[0])};
         eo  = (sel < 3) ? ref_model(l1[sel], l2[sel], 1'b0) : 9'd0;
         if_odd.in1 = p1; if_odd.in2 = p2; if_odd.select = 2'(sel); if_odd.in_valid = 1'b1;
         @(posedge clk); #1;
         vectors++;
         if ({if_odd.borrow, if_odd.sub_out, if_odd.out_valid} !== {eo, 1'b1}) begin
            miscompares++;
            $display("FAIL rand_odd[%0d] sel=%0d: got sub=%0d bor=%0b val=%0b want %0d/%0b/1",
                     n, sel, if_odd.sub_out, if_odd.borrow, if_odd.out_valid, eo[7:0], eo[8]);
         end
      end
      if_odd.in_valid = 1'b0;
   endtask

   initial begin
      reset = 1'b1;
      if_odd.in1 = '0; if_odd.in2 = '0; if_odd.select = '0; if_odd.in_valid = 1'b0;
      #1;
      test_reset();
      test_first_lane();
      test_lane_switch();
      test_nonneg_equal();
      test_saturation();
      test_streaming();
      test_reset_midstream();
      test_out_of_range();
      test_random();
      test_random_odd();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end
endmodule
